// File: rtl/bp_noc_wormhole_rx_deserializer.sv
// Receive endpoint of a credit-flow-controlled wormhole link: buffers flits, reassembles header+body into one word.
// Optional statistics ports (packet_count_o, credit_starve_o) are built when BP_NOC_RX_STATS_EN is defined.
module bp_noc_wormhole_rx_deserializer #(
    parameter int flit_width_p  = 64,
    parameter int len_width_p   = 4,
    parameter int cid_width_p   = 2,
    parameter int max_credits_p = 8,
    localparam int max_payload_flits_lp = (1 << len_width_p) - 1
) (
    input  logic                                             clk_i,
    input  logic                                             reset_i,
    input  logic                                             link_v_i,
    input  logic [flit_width_p-1:0]                          link_data_i,
    output logic                                             link_credit_o,
    output logic [flit_width_p*(max_payload_flits_lp+1)-1:0] packet_o,
    output logic [len_width_p-1:0]                           packet_len_o,
    output logic [cid_width_p-1:0]                           packet_cid_o,
    output logic                                             packet_v_o,
    input  logic                                             packet_yumi_i,
    output logic                                             overflow_o
`ifdef BP_NOC_RX_STATS_EN
    ,
    output logic [31:0]                                      packet_count_o,
    output logic                                             credit_starve_o
`endif
);

    localparam int ptr_w_lp = (max_credits_p > 1) ? $clog2(max_credits_p) : 1;
    localparam int cnt_w_lp = $clog2(max_credits_p + 1);

    typedef enum logic [1:0] {
        e_header = 2'd0,
        e_body   = 2'd1,
        e_out    = 2'd2
    } state_e;

    state_e state_q, state_n;

    logic [flit_width_p-1:0] fifo_mem [max_credits_p];
    logic [ptr_w_lp-1:0]     wr_ptr_q, rd_ptr_q;
    logic [cnt_w_lp-1:0]     count_q;
    logic                    fifo_empty, fifo_full, enq, deq;
    logic [flit_width_p-1:0] head_flit;
    logic [len_width_p-1:0]  head_len;
    logic [cid_width_p-1:0]  head_cid;

    logic [max_payload_flits_lp:0][flit_width_p-1:0] packet_q;
    logic [len_width_p-1:0]  len_q, cnt_q, body_idx;
    logic [cid_width_p-1:0]  cid_q;
    logic                    overflow_q;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(max_credits_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == cnt_w_lp'(max_credits_p));
    assign head_flit  = fifo_mem[rd_ptr_q];
    assign head_len   = head_flit[len_width_p-1:0];
    assign head_cid   = head_flit[len_width_p+cid_width_p-1:len_width_p];
    assign body_idx   = cnt_q + len_width_p'(1);

    // A full FIFO still accepts a flit in a cycle that also drains one.
    assign deq = !fifo_empty && (state_q != e_out);
    assign enq = link_v_i && (!fifo_full || deq);

    always_ff @(posedge clk_i) begin
        if (enq) begin
            fifo_mem[wr_ptr_q] <= link_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (enq) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (deq) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({enq, deq})
                2'b10:   count_q <= count_q + cnt_w_lp'(1);
                2'b01:   count_q <= count_q - cnt_w_lp'(1);
                default: count_q <= count_q;
            endcase
            if (link_v_i && fifo_full && !deq) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= e_header;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            e_header: if (deq) state_n = (head_len == '0) ? e_out : e_body;
            e_body:   if (deq && (body_idx == len_q)) state_n = e_out;
            e_out:    if (packet_yumi_i) state_n = e_header;
            default:  state_n = e_header;
        endcase
    end

    // body_idx never exceeds len_q, so the final slot is reachable without counter wrap.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            packet_q <= '0;
            len_q    <= '0;
            cid_q    <= '0;
            cnt_q    <= '0;
        end else if (deq) begin
            if (state_q == e_header) begin
                packet_q    <= '0;
                packet_q[0] <= head_flit;
                len_q       <= head_len;
                cid_q       <= head_cid;
                cnt_q       <= '0;
            end else begin
                packet_q[body_idx] <= head_flit;
                cnt_q              <= body_idx;
            end
        end
    end

    // valid/yumi: packet_v_o stays high with packet fields frozen until the cycle packet_yumi_i is
    // sampled high; yumi is only legal while packet_v_o is high.
    assign packet_o      = packet_q;
    assign packet_len_o  = len_q;
    assign packet_cid_o  = cid_q;
    assign packet_v_o    = (state_q == e_out);
    assign link_credit_o = deq;
    assign overflow_o    = overflow_q;

`ifdef BP_NOC_RX_STATS_EN
    logic [31:0] packet_count_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            packet_count_q <= '0;
        end else if (packet_yumi_i && packet_v_o) begin
            packet_count_q <= packet_count_q + 32'd1;
        end
    end

    assign packet_count_o  = packet_count_q;
    assign credit_starve_o = !reset_i && (state_q == e_header) && fifo_empty;
`endif

endmodule

// File: tb/tb_bp_noc_wormhole_rx_deserializer.sv
// Randomized bench for bp_noc_wormhole_rx_deserializer with a packet-level reference model and credit-honouring sender.
module tb_bp_noc_wormhole_rx_deserializer;

    localparam int FW = 64;
    localparam int LW = 4;
    localparam int CW = 2;
    localparam int MC = 8;
    localparam int NF = 16;
    localparam int PW = FW * NF;
    localparam int EW = PW + LW + CW;

    logic          clk_i;
    logic          reset_i;
    logic          link_v_i;
    logic [FW-1:0] link_data_i;
    logic          link_credit_o;
    logic [PW-1:0] packet_o;
    logic [LW-1:0] packet_len_o;
    logic [CW-1:0] packet_cid_o;
    logic          packet_v_o;
    logic          packet_yumi_i;
    logic          overflow_o;
`ifdef BP_NOC_RX_STATS_EN
    logic [31:0]   packet_count_o;
    logic          credit_starve_o;
`endif

    logic cons_en, cons_yumi, man_yumi;
    assign packet_yumi_i = cons_en ? cons_yumi : man_yumi;

    bp_noc_wormhole_rx_deserializer #(
        .flit_width_p(FW), .len_width_p(LW), .cid_width_p(CW), .max_credits_p(MC)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .link_v_i(link_v_i),
        .link_data_i(link_data_i),
        .link_credit_o(link_credit_o),
        .packet_o(packet_o),
        .packet_len_o(packet_len_o),
        .packet_cid_o(packet_cid_o),
        .packet_v_o(packet_v_o),
        .packet_yumi_i(packet_yumi_i),
        .overflow_o(overflow_o)
`ifdef BP_NOC_RX_STATS_EN
        ,
        .packet_count_o(packet_count_o),
        .credit_starve_o(credit_starve_o)
`endif
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int passed = 0;
    int total = 0;
    int credits = MC;
    int credit_pulses = 0;
    int consumed = 0;
    int pkt_idx = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // scoreboard: credit accounting and packet comparison at mid-cycle
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (link_credit_o) begin
                credits++;
                credit_pulses++;
            end
            if (packet_v_o && packet_yumi_i) begin
                consumed++;
                if (exp_q.size() == 0) begin
                    check("unexpected_packet", 64'(exp_q.size()), 64'd1);
                end else begin
                    logic [EW-1:0] e;
                    logic [NF-1:0][FW-1:0] e_data;
                    e = exp_q.pop_front();
                    e_data = e[CW+LW +: PW];
                    check($sformatf("pkt%0d_len", pkt_idx), 64'(packet_len_o), 64'(e[CW +: LW]));
                    check($sformatf("pkt%0d_cid", pkt_idx), 64'(packet_cid_o), 64'(e[CW-1:0]));
                    for (int k = 0; k < NF; k++)
                        check($sformatf("pkt%0d_flit%0d", pkt_idx, k), packet_o[k*FW +: FW], e_data[k]);
                end
                pkt_idx++;
            end
        end
    end

    // random consumer
    always @(posedge clk_i) begin
        #1;
        cons_yumi = packet_v_o && ($urandom_range(0, 2) == 0);
    end

    // driver tasks
    task automatic push_exp(input logic [NF-1:0][FW-1:0] d, input logic [LW-1:0] len, input logic [CW-1:0] cid);
        exp_q.push_back({d, len, cid});
    endtask

    task automatic push_hdr_only(input logic [FW-1:0] hdr);
        logic [NF-1:0][FW-1:0] d;
        d = '0;
        d[0] = hdr;
        push_exp(d, hdr[LW-1:0], hdr[LW+CW-1:LW]);
    endtask

    task automatic drive_flit(input logic [FW-1:0] data);
        link_v_i = 1'b1;
        link_data_i = data;
        tick();
        link_v_i = 1'b0;
    endtask

    task automatic send_flit(input logic [FW-1:0] data);
        int n = 0;
        while (credits <= 0 && n < 500) begin
            tick();
            n++;
        end
        check("credit_wait", 64'(credits > 0), 64'd1);
        credits--;
        drive_flit(data);
    endtask

    task automatic send_packet(input logic [LW-1:0] len, input logic [CW-1:0] cid,
                               input int gap_max, input bit directed);
        logic [NF-1:0][FW-1:0] d;
        logic [FW-1:0] hdr;
        d = '0;
        hdr = {$urandom(), $urandom()};
        hdr[LW-1:0] = len;
        hdr[LW+CW-1:LW] = cid;
        d[0] = hdr;
        for (int k = 1; k <= int'(len); k++)
            d[k] = directed ? FW'(k) : {$urandom(), $urandom()};
        push_exp(d, len, cid);
        for (int k = 0; k <= int'(len); k++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
            send_flit(d[k]);
        end
    endtask

    task automatic wait_v(input string tag);
        int n = 0;
        while (!packet_v_o && n < 200) begin
            tick();
            n++;
        end
        check(tag, 64'(packet_v_o), 64'd1);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || packet_v_o) && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic yumi_pulse();
        man_yumi = 1'b1;
        tick();
        man_yumi = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        link_v_i = 1'b0;
        man_yumi = 1'b0;
        cons_en = 1'b0;
        exp_q.delete();
        credits = MC;
        credit_pulses = 0;
        consumed = 0;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    initial begin
        int c0;
        int flits_sent;
        reset_i = 1'b1;
        link_v_i = 1'b0;
        link_data_i = '0;
        man_yumi = 1'b0;
        cons_en = 1'b0;
        #1;
        check("rst_v", 64'(packet_v_o), 64'd0);
        check("rst_credit", 64'(link_credit_o), 64'd0);
        check("rst_overflow", 64'(overflow_o), 64'd0);
        check("rst_len", 64'(packet_len_o), 64'd0);
        check("rst_cid", 64'(packet_cid_o), 64'd0);
        check("rst_flit0", packet_o[FW-1:0], 64'd0);
`ifdef BP_NOC_RX_STATS_EN
        check("rst_count", 64'(packet_count_o), 64'd0);
        check("rst_starve", 64'(credit_starve_o), 64'd0);
`endif
        tick();
        tick();
        reset_i = 1'b0;
        #1;
        check("post_rst_v", 64'(packet_v_o), 64'd0);

        // header-only packet latency
        push_hdr_only(64'h10);
        send_flit(64'h10);
        check("hdr_deq_credit", 64'(link_credit_o), 64'd1);
        check("hdr_deq_v", 64'(packet_v_o), 64'd0);
        tick();
        check("hdr_v", 64'(packet_v_o), 64'd1);
        check("hdr_len", 64'(packet_len_o), 64'd0);
        check("hdr_cid", 64'(packet_cid_o), 64'd1);
        check("hdr_out_credit", 64'(link_credit_o), 64'd0);
        yumi_pulse();
        check("hdr_after_yumi_v", 64'(packet_v_o), 64'd0);
        check("hdr_credit_total", 64'(credit_pulses), 64'd1);

        // max-length packet, held until yumi
        c0 = credit_pulses;
        send_packet(4'd15, 2'd3, 0, 1'b1);
        wait_v("max_wait_v");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("max_v_held", 64'(packet_v_o), 64'd1);
        end
        check("max_last_flit", packet_o[15*FW +: FW], 64'd15);
        check("max_credits", 64'(credit_pulses - c0), 64'd16);
        yumi_pulse();

        // back-pressure: two len=3 packets while consumer stalls
        c0 = credit_pulses;
        send_packet(4'd3, 2'd2, 0, 1'b0);
        send_packet(4'd3, 2'd1, 0, 1'b0);
        repeat (10) tick();
        check("bp_v", 64'(packet_v_o), 64'd1);
        check("bp_credits_stalled", 64'(credit_pulses - c0), 64'd4);
        yumi_pulse();
        wait_v("bp_wait_v2");
        check("bp_credits_total", 64'(credit_pulses - c0), 64'd8);
        yumi_pulse();

        // randomized traffic with random consumer
        cons_en = 1'b1;
        c0 = credit_pulses;
        flits_sent = 0;
        for (int p = 0; p < 20; p++) begin
            int len;
            len = $urandom_range(0, 15);
            flits_sent += len + 1;
            send_packet(LW'(len), CW'($urandom_range(0, 3)), 2, 1'b0);
        end
        wait_drain("rand_drain");
        repeat (3) tick();
        check("rand_credits", 64'(credit_pulses - c0), 64'(flits_sent));
        check("rand_credit_balance", 64'(credits), 64'(MC));
        check("rand_no_overflow", 64'(overflow_o), 64'd0);

        // overflow: stall in e_out, fill, then one extra flit
        do_reset();
        drive_flit(64'h0);
        for (int i = 0; i < MC; i++) drive_flit({$urandom(), $urandom()} & ~64'hF);
        check("ovf_full_no_flag", 64'(overflow_o), 64'd0);
        check("ovf_stalled_v", 64'(packet_v_o), 64'd1);
        drive_flit(64'h20);
        check("ovf_set", 64'(overflow_o), 64'd1);
        repeat (5) tick();
        check("ovf_sticky", 64'(overflow_o), 64'd1);

        // full FIFO with same-cycle dequeue: no overflow
        do_reset();
        begin
            logic [FW-1:0] h;
            h = {$urandom(), $urandom()} & ~64'hF;
            push_hdr_only(h);
            drive_flit(h);
            for (int i = 0; i < MC; i++) begin
                h = {$urandom(), $urandom()} & ~64'hF;
                push_hdr_only(h);
                drive_flit(h);
            end
            yumi_pulse();
            check("sim_deq_credit", 64'(link_credit_o), 64'd1);
            h = {$urandom(), $urandom()} & ~64'hF;
            push_hdr_only(h);
            drive_flit(h);
            check("sim_no_overflow", 64'(overflow_o), 64'd0);
        end
        cons_en = 1'b1;
        wait_drain("sim_drain");
        check("sim_no_overflow_end", 64'(overflow_o), 64'd0);

        // reset mid-packet
        do_reset();
        send_flit(64'hABCD_0000_0000_0023);
        send_flit(64'h1111);
        reset_i = 1'b1;
        #1;
        check("midrst_v", 64'(packet_v_o), 64'd0);
        check("midrst_len", 64'(packet_len_o), 64'd0);
        check("midrst_flit0", packet_o[FW-1:0], 64'd0);
        check("midrst_credit", 64'(link_credit_o), 64'd0);
        tick();
        reset_i = 1'b0;
        credits = MC;
        credit_pulses = 0;
        consumed = 0;
        cons_en = 1'b1;
        send_packet(4'd1, 2'd2, 0, 1'b0);
        wait_drain("midrst_drain");
        check("midrst_credits", 64'(credit_pulses), 64'd2);

`ifdef BP_NOC_RX_STATS_EN
        do_reset();
        cons_en = 1'b1;
        for (int p = 0; p < 3; p++) send_packet(LW'($urandom_range(0, 4)), CW'(p), 1, 1'b0);
        wait_drain("stats_drain");
        repeat (3) tick();
        check("stats_count", 64'(packet_count_o), 64'(consumed));
        check("stats_count3", 64'(packet_count_o), 64'd3);
        check("stats_starve", 64'(credit_starve_o), 64'd1);
`endif

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
